sumador_serial: RTL and testbench
=================================

# sumador_serial

Bit-serial N-bit adder: the addition-side counterpart of the team's 1-bit subtractor. It reconstructs A = D + B from a difference and a subtrahend, or performs any plain addition. It accepts two operands and a carry-in on a start pulse, then processes one bit per clock, LSB first, through a single full-adder cell and a carry flip-flop. It presents sum, carry-out and signed overflow with a one-cycle done pulse. It sits beside the subtractor datapath in the ALU and trades latency for one adder cell of area.

## Interface
- WIDTH, 8, operand and sum width in bits (≥2)
- clk  input  1  clock, rising-edge active
- rst  input  1  reset, synchronous, active-high
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A; captured on accepted start
- b  input  WIDTH  operand B; captured on accepted start
- ci  input  1  carry-in; captured on accepted start
- busy  output  1  high whenever state ≠ IDLE
- done  output  1  one-cycle pulse; result valid
- sum  output  WIDTH  a + b + ci, modulo 2^WIDTH
- co  output  1  unsigned carry-out of the MSB
- overflow  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB

## Operation
- Reset (rst=1 at a clock edge) forces the following, regardless of state:
  - state=IDLE, busy=0, done=0
  - sum=0, co=0, overflow=0
  - internal shift registers, carry FF and bit counter cleared
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1:
  - latch a and b into shift registers; latch ci into the carry FF
  - bit counter=0; go to RUN
- IDLE, start=0: stay in IDLE; sum/co/overflow hold their last values.
- RUN, each edge:
  - s = a_lsb ^ b_lsb ^ c; c' = majority(a_lsb, b_lsb, c)
  - s shifts into the sum register from the MSB side; operand registers shift right
  - counter increments
  - the edge processing bit WIDTH-2 also records the carry into the MSB, for overflow
  - the edge processing bit WIDTH-1 (counter==WIDTH-1) writes final sum, co=c', overflow=c_in_msb ^ c', then goes to DONE
- DONE: done=1 for exactly that cycle, then unconditionally to IDLE.
- start while RUN or DONE is ignored; no queueing.
- Operand inputs a, b, ci are don't-care after the accepting edge; changes mid-operation do not affect the result.
- The sum register is visible while shifting. During RUN it holds partial bits and is not valid; sum/co/overflow are valid from the DONE cycle until the next accepted start.
- Arithmetic is unsigned modulo 2^WIDTH; co and overflow are both reported, and the user selects the interpretation.

## Timing
- Accepting edge E0 (IDLE, start=1): busy=1 from the cycle after E0.
- RUN occupies edges E1..E_WIDTH; state=DONE after E_WIDTH.
- done is high in the cycle after E_WIDTH, i.e. WIDTH cycles after the start was sampled. busy is still 1 in that cycle.
- Edge E_WIDTH+1 returns to IDLE: busy=0, done=0. A start in that cycle is accepted at E_WIDTH+2.
- Throughput: one operation per WIDTH+2 cycles with start held high.
- rst has priority over start at the same edge. Reset mid-RUN aborts the operation and zeroes all outputs on the next cycle; no partial result survives.
- start=1 on the same edge rst deasserts (rst=0, start=1, state IDLE) is accepted normally.
- No combinational path from inputs to outputs; all outputs are registered.

## Test plan
- WIDTH=8, a=0x25, b=0x1A, ci=0, start pulse:
  - busy rises next cycle; done is high exactly 8 cycles after start is sampled
  - sum=0x3F, co=0, overflow=0; done lasts 1 cycle, busy falls the following cycle
- a=0xFF, b=0x01, ci=0 → sum=0x00, co=1, overflow=0.
- a=0x7F, b=0x01, ci=0 → sum=0x80, co=0, overflow=1.
- a=0x80, b=0x80, ci=0 → sum=0x00, co=1, overflow=1.
- a=0x00, b=0x00, ci=1 → sum=0x01, co=0, overflow=0.
- Reconstruction check: a=0x33 (=0x5A−0x27), b=0x27, ci=0 → sum=0x5A, co=0, overflow=0.
- a=0x10, b=0x20 started:
  - then drive a=0xFF, b=0xFF and pulse start at cycle 3 of RUN → ignored; result sum=0x30, done exactly once
  - then assert rst at cycle 4 of a new operation → next cycle busy=0, done=0, sum=0, co=0, overflow=0; no done pulse follows
  - a subsequent start with a=0x01, b=0x02 yields sum=0x03

Source files
------------

// File: rtl/sumador_serial_if.sv
// Operand/result bundle for the bit-serial adder; master issues start, slave returns the result.
// No backpressure: start is only honoured while the slave is idle.
interface sumador_serial_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             co;
  logic             overflow;

  modport master (
    output start, a, b, ci,
    input  busy, done, sum, co, overflow
  );

  modport slave (
    input  start, a, b, ci,
    output busy, done, sum, co, overflow
  );
endinterface

// File: rtl/sumador_serial.sv
// Bit-serial adder, one full-adder cell, LSB first; done pulses WIDTH cycles after start is sampled.
// No backpressure: start is ignored while busy, so one operation per WIDTH+2 cycles at best.
module sumador_serial #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  sumador_serial_if.slave bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic             c;
  logic             c_msb;
  logic [CW-1:0]    cnt;
  logic             s;
  logic             cn;

  assign s  = sa[0] ^ sb[0] ^ c;
  assign cn = (sa[0] & sb[0]) | (sa[0] & c) | (sb[0] & c);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.sum      <= '0;
      bus.co       <= 1'b0;
      bus.overflow <= 1'b0;
      sa           <= '0;
      sb           <= '0;
      c            <= 1'b0;
      c_msb        <= 1'b0;
      cnt          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            sa       <= bus.a;
            sb       <= bus.b;
            c        <= bus.ci;
            c_msb    <= 1'b0;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          // sum doubles as the result shift register; it is only meaningful once done fires
          bus.sum <= {s, bus.sum[WIDTH-1:1]};
          sa      <= sa >> 1;
          sb      <= sb >> 1;
          c       <= cn;
          cnt     <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 2)) begin
            c_msb <= cn;
          end
          if (cnt == CW'(WIDTH - 1)) begin
            bus.co       <= cn;
            bus.overflow <= c_msb ^ cn;
            bus.done     <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sumador_serial.sv
// Self-checking bench for sumador_serial: directed vector table, random operands against an
// arithmetic reference, and hand-written start-while-busy / reset-abort sequences.
module tb_sumador_serial;
  localparam int W = 8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  sumador_serial_if #(.WIDTH(W)) bus ();

  sumador_serial #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W-1:0] sum;
    logic         co;
    logic         ov;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer addition, signed overflow from operand/result sign bits.
  task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                       output logic [W-1:0] s, output logic co, output logic ov);
    int t;
    t  = int'(x) + int'(y) + int'(c);
    s  = W'(t % (1 << W));
    co = (t >= (1 << W));
    ov = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
  endtask

  // Starts one operation from IDLE (caller sits #1 after an edge) and waits for done.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_b, input logic tci,
                        output logic [W-1:0] rs, output logic rco, output logic rov,
                        output int lat);
    bus.a     = ta;
    bus.b     = tb_b;
    bus.ci    = tci;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("busy_after_start", 32'(bus.busy), 32'd1);
    lat = 0;
    while (!bus.done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rs  = bus.sum;
    rco = bus.co;
    rov = bus.overflow;
    chk("busy_in_done", 32'(bus.busy), 32'd1);
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(bus.done), 32'd0);
    chk("busy_falls", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    logic [W-1:0] rs, es, ra, rb;
    logic         rco, rov, eco, eov, rc;
    int           lat, ndone;

    checks = 0;
    errors = 0;

    vecs[0] = '{a: 8'h25, b: 8'h1A, ci: 1'b0, sum: 8'h3F, co: 1'b0, ov: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, ci: 1'b0, sum: 8'h00, co: 1'b1, ov: 1'b0};
    vecs[2] = '{a: 8'h7F, b: 8'h01, ci: 1'b0, sum: 8'h80, co: 1'b0, ov: 1'b1};
    vecs[3] = '{a: 8'h80, b: 8'h80, ci: 1'b0, sum: 8'h00, co: 1'b1, ov: 1'b1};
    vecs[4] = '{a: 8'h00, b: 8'h00, ci: 1'b1, sum: 8'h01, co: 1'b0, ov: 1'b0};
    vecs[5] = '{a: 8'h33, b: 8'h27, ci: 1'b0, sum: 8'h5A, co: 1'b0, ov: 1'b0};

    // Reset with start held high: reset must win over start.
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.a     = 8'hAA;
    bus.b     = 8'h55;
    bus.ci    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_sum", 32'(bus.sum), 32'd0);
    chk("rst_co", 32'(bus.co), 32'd0);
    chk("rst_ov", 32'(bus.overflow), 32'd0);
    bus.start = 1'b0;
    rst       = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].ci, rs, rco, rov, lat);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(W));
      chk($sformatf("vec%0d_sum", i), 32'(rs), 32'(vecs[i].sum));
      chk($sformatf("vec%0d_co", i), 32'(rco), 32'(vecs[i].co));
      chk($sformatf("vec%0d_ov", i), 32'(rov), 32'(vecs[i].ov));
      chk($sformatf("vec%0d_sum_hold", i), 32'(bus.sum), 32'(vecs[i].sum));
    end

    for (int n = 0; n < 40; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      model(ra, rb, rc, es, eco, eov);
      run_op(ra, rb, rc, rs, rco, rov, lat);
      chk("rand_latency", 32'(lat), 32'(W));
      chk("rand_sum", 32'(rs), 32'(es));
      chk("rand_co", 32'(rco), 32'(eco));
      chk("rand_ov", 32'(rov), 32'(eov));
    end

    // Start during RUN with new operands must be ignored.
    bus.a = 8'h10; bus.b = 8'h20; bus.ci = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    bus.a = 8'hFF; bus.b = 8'hFF; bus.ci = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    ndone = 0;
    rs    = '0;
    rco   = 1'b1;
    for (int i = 0; i < W + 8; i++) begin
      if (bus.done) begin
        ndone++;
        rs  = bus.sum;
        rco = bus.co;
      end
      @(posedge clk); #1;
    end
    chk("ignored_start_done_count", 32'(ndone), 32'd1);
    chk("ignored_start_sum", 32'(rs), 32'h30);
    chk("ignored_start_co", 32'(rco), 32'd0);
    chk("ignored_start_idle", 32'(bus.busy), 32'd0);

    // Reset mid-operation aborts it with no trailing done.
    bus.a = 8'h55; bus.b = 8'h66; bus.ci = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_sum", 32'(bus.sum), 32'd0);
    chk("abort_co", 32'(bus.co), 32'd0);
    chk("abort_ov", 32'(bus.overflow), 32'd0);
    ndone = 0;
    for (int i = 0; i < W + 4; i++) begin
      if (bus.done) ndone++;
      @(posedge clk); #1;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);

    run_op(8'h01, 8'h02, 1'b0, rs, rco, rov, lat);
    chk("post_abort_sum", 32'(rs), 32'h03);
    chk("post_abort_latency", 32'(lat), 32'(W));

    // Start already high on the edge where reset deasserts is accepted.
    rst = 1'b1;
    bus.a = 8'h0F; bus.b = 8'hF0; bus.ci = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("rst_release_accept", 32'(bus.busy), 32'd1);
    lat = 0;
    while (!bus.done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("rst_release_latency", 32'(lat), 32'(W));
    chk("rst_release_sum", 32'(bus.sum), 32'h00);
    chk("rst_release_co", 32'(bus.co), 32'd1);
    chk("rst_release_ov", 32'(bus.overflow), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
